// File: rtl/coin_feeder.sv
// Customer-side coin driver: feeds COIN_PER_COLA coin pulses per requested cola into the vending FSM and counts acks.
// Optional: define COIN_FEEDER_RANDOM_GAP_EN to take gap lengths (1-4 cycles) from an 8-bit LFSR instead of GAP_CNT.
module coin_feeder #(
    parameter int COIN_PER_COLA = 3,
    parameter int GAP_CNT       = 2,
    parameter int TIMEOUT       = 8,
    parameter int CNT_W         = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             buy_req,
    input  logic [CNT_W-1:0] buy_num,
    input  logic             po_cola,
    output logic             pi_money,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cola_cnt
);
    localparam int COIN_W = $clog2(COIN_PER_COLA + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int GAP_W  = $clog2(GAP_CNT + 4);

    typedef enum logic [1:0] {IDLE, COIN, GAP, WAIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  cola_cnt_q, cola_cnt_d;
    logic [COIN_W-1:0] coin_cnt_q, coin_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]  gap_left_q, gap_left_d;
    logic              pi_money_q, pi_money_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [GAP_W-1:0]  gap_load;
    logic [CNT_W-1:0]  cola_inc;
    logic              last_coin;
    logic              ack;

`ifdef COIN_FEEDER_RANDOM_GAP_EN
    logic [7:0] lfsr_q, lfsr_d;

    // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign gap_load = GAP_W'(lfsr_q[1:0]);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign gap_load = GAP_W'(GAP_CNT - 1);
`endif

    assign cola_inc  = cola_cnt_q + 1'b1;
    assign last_coin = (coin_cnt_q == COIN_W'(COIN_PER_COLA - 1));
    // An ack during the final coin cycle counts, so a Mealy-style vending FSM is handled.
    assign ack = po_cola && ((state_q == WAIT) || ((state_q == COIN) && last_coin));

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        cola_cnt_d = cola_cnt_q;
        coin_cnt_d = coin_cnt_q;
        to_cnt_d   = to_cnt_q;
        gap_left_d = gap_left_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (buy_req) begin
                    cola_cnt_d = '0;
                    coin_cnt_d = '0;
                    if (buy_num != '0) begin
                        num_d   = buy_num;
                        state_d = COIN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            COIN: begin
                coin_cnt_d = coin_cnt_q + 1'b1;
                if (last_coin) begin
                    to_cnt_d = '0;
                    state_d  = WAIT;
                end else begin
                    gap_left_d = gap_load;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (gap_left_q == '0) begin
                    state_d = COIN;
                end else begin
                    gap_left_d = gap_left_q - 1'b1;
                end
            end
            WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (!po_cola && (to_cnt_q == TO_W'(TIMEOUT - 1))) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase

        if (ack) begin
            cola_cnt_d = cola_inc;
            coin_cnt_d = '0;
            if (cola_inc == num_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                gap_left_d = gap_load;
                state_d    = GAP;
            end
        end

        pi_money_d = (state_d == COIN);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            num_q      <= '0;
            cola_cnt_q <= '0;
            coin_cnt_q <= '0;
            to_cnt_q   <= '0;
            gap_left_q <= '0;
            pi_money_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            cola_cnt_q <= cola_cnt_d;
            coin_cnt_q <= coin_cnt_d;
            to_cnt_q   <= to_cnt_d;
            gap_left_q <= gap_left_d;
            pi_money_q <= pi_money_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign pi_money = pi_money_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign cola_cnt = cola_cnt_q;
endmodule

// File: tb/tb_coin_feeder.sv
// Bench for coin_feeder: table of purchase transactions checked against a cycle scoreboard of expected coins and done/err events.
module tb_coin_feeder;
    localparam int CPC = 3;
    localparam int GAP = 2;
    localparam int TO  = 8;
    localparam int CW  = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          buy_req;
    logic [CW-1:0] buy_num;
    logic          po_cola;
    logic          pi_money;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] cola_cnt;

    coin_feeder #(
        .COIN_PER_COLA(CPC),
        .GAP_CNT      (GAP),
        .TIMEOUT      (TO),
        .CNT_W        (CW)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .buy_req  (buy_req),
        .buy_num  (buy_num),
        .po_cola  (po_cola),
        .pi_money (pi_money),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cola_cnt (cola_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

`ifdef COIN_FEEDER_RANDOM_GAP_EN
    logic [7:0] lfsr_m;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) lfsr_m <= 8'hA5;
        else            lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
`endif

    typedef struct {
        int cyc;
        int cola;
        bit dn;
        bit er;
    } ev_t;

    typedef struct {
        logic [CW-1:0] n;
        int            mode;   // 0 never ack, 1 ack after last coin, 2 ack during last coin, 3 like 1 plus stray acks
        bit            extra;  // second buy_req while busy
        int            coins;
        int            colas;
        bit            dn;
        bit            er;
    } vec_t;

    int  coin_q[$];
    ev_t ev_q[$];

    int checks = 0;
    int failures = 0;
    int exp_n, exp_cola, coin_in_cola, ack_mode, coin_total, end_cyc;
    bit ack_next = 1'b0;
    bit txn_over, saw_done, saw_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int gap_len();
`ifdef COIN_FEEDER_RANDOM_GAP_EN
        return int'(lfsr_m[1:0]) + 1;
`else
        return GAP;
`endif
    endfunction

    task automatic push_ev(input int c, input int cola, input bit dn, input bit er);
        ev_t e;
        e.cyc  = c;
        e.cola = cola;
        e.dn   = dn;
        e.er   = er;
        ev_q.push_back(e);
    endtask

    task automatic handle_ack();
        exp_cola++;
        push_ev(cyc + 1, exp_cola, exp_cola == exp_n, 1'b0);
        if (exp_cola != exp_n) coin_q.push_back(cyc + gap_len() + 1);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        buy_req = 1'b0;
        po_cola = ack_next;
        if (ack_next) handle_ack();
        ack_next = 1'b0;
    endtask

    task automatic sample();
        ev_t e;
        @(negedge sys_clk);
        if (pi_money === 1'b1) begin
            coin_total++;
            chk("busy_during_coin", 32'(busy), 1);
            if (coin_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL coin_unexpected: pi_money=1 at cycle %0d, required 0", cyc);
            end else begin
                chk("coin_cycle", cyc, coin_q.pop_front());
            end
            coin_in_cola++;
            if (coin_in_cola >= CPC) begin
                coin_in_cola = 0;
                case (ack_mode)
                    0:       push_ev(cyc + 1 + TO, exp_cola, 1'b0, 1'b1);
                    2:       begin po_cola = 1'b1; handle_ack(); end
                    default: ack_next = 1'b1;
                endcase
            end else begin
                coin_q.push_back(cyc + gap_len() + 1);
                if (ack_mode == 3) po_cola = 1'b1;
            end
        end else if (coin_q.size() != 0 && coin_q[0] <= cyc) begin
            checks++;
            failures++;
            $display("FAIL coin_missing: pi_money=0 at cycle %0d, required 1 at cycle %0d", cyc, coin_q[0]);
            void'(coin_q.pop_front());
        end
        if (done === 1'b1) saw_done = 1'b1;
        if (err === 1'b1)  saw_err  = 1'b1;
        if (ev_q.size() != 0 && ev_q[0].cyc == cyc) begin
            e = ev_q.pop_front();
            chk("ev_done", 32'(done), 32'(e.dn));
            chk("ev_err", 32'(err), 32'(e.er));
            chk("ev_cola_cnt", 32'(cola_cnt), e.cola);
            chk("ev_busy", 32'(busy), 32'(!(e.dn || e.er)));
            if (e.dn || e.er) begin
                txn_over = 1'b1;
                end_cyc  = cyc;
            end
        end else begin
            chk("no_stray_done_err", {30'd0, done, err}, 0);
        end
    endtask

    task automatic run_txn(input logic [CW-1:0] n, input int mode, input bit extra,
                           output int coins, output bit got_done, output bit got_err, output int lat);
        int req_cyc;
        tick();
        buy_req      = 1'b1;
        buy_num      = n;
        req_cyc      = cyc;
        exp_n        = int'(n);
        exp_cola     = 0;
        coin_in_cola = 0;
        ack_mode     = mode;
        txn_over     = 1'b0;
        coin_total   = 0;
        saw_done     = 1'b0;
        saw_err      = 1'b0;
        end_cyc      = cyc;
        if (n == '0) push_ev(cyc + 1, 0, 1'b1, 1'b0);
        else         coin_q.push_back(cyc + 1);
        for (int i = 0; i < 300 && !txn_over; i++) begin
            sample();
            if (!txn_over) begin
                tick();
                if (extra && i == 3) begin
                    buy_req = 1'b1;
                    buy_num = 4'd5;
                end
            end
        end
        if (!txn_over) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout: no done/err within 300 cycles, required one (n=%0d)", n);
        end
        chk("coin_queue_drained", coin_q.size(), 0);
        coins    = coin_total;
        got_done = saw_done;
        got_err  = saw_err;
        lat      = end_cyc - req_cyc;
        coin_q.delete();
        ev_q.delete();
    endtask

    task automatic idle(input int k, input logic [CW-1:0] hold_cnt);
        for (int i = 0; i < k; i++) begin
            tick();
            if (i == 1) po_cola = 1'b1;
            sample();
        end
        chk("cola_cnt_hold", 32'(cola_cnt), 32'(hold_cnt));
    endtask

    vec_t vecs[7];

    initial begin
        int coins, lat;
        bit gd, ge;

        vecs[0] = '{4'd1, 1, 1'b0, 3, 1, 1'b1, 1'b0};
        vecs[1] = '{4'd3, 1, 1'b0, 9, 3, 1'b1, 1'b0};
        vecs[2] = '{4'd2, 0, 1'b0, 3, 0, 1'b0, 1'b1};
        vecs[3] = '{4'd0, 1, 1'b0, 0, 0, 1'b1, 1'b0};
        vecs[4] = '{4'd2, 1, 1'b1, 6, 2, 1'b1, 1'b0};
        vecs[5] = '{4'd2, 2, 1'b0, 6, 2, 1'b1, 1'b0};
        vecs[6] = '{4'd3, 3, 1'b0, 9, 3, 1'b1, 1'b0};

        sys_rst_n = 1'b0;
        buy_req   = 1'b0;
        buy_num   = '0;
        po_cola   = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("rst_pi_money", 32'(pi_money), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cola_cnt", 32'(cola_cnt), 0);
        sys_rst_n = 1'b1;
        idle(2, '0);

        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].n, vecs[v].mode, vecs[v].extra, coins, gd, ge, lat);
            chk("txn_coins", coins, vecs[v].coins);
            chk("txn_cola_cnt", 32'(cola_cnt), vecs[v].colas);
            chk("txn_done_seen", 32'(gd), 32'(vecs[v].dn));
            chk("txn_err_seen", 32'(ge), 32'(vecs[v].er));
            $display("txn %0d: n=%0d mode=%0d extra=%0b coins=%0d cola_cnt=%0d done=%0b err=%0b cycles=%0d",
                     v, vecs[v].n, vecs[v].mode, vecs[v].extra, coins, cola_cnt, gd, ge, lat);
            idle(3, 4'(vecs[v].colas));
        end

`ifndef COIN_FEEDER_RANDOM_GAP_EN
        run_txn(4'd1, 1, 1'b0, coins, gd, ge, lat);
        chk("n1_done_latency", lat, 1 + (CPC - 1) * (GAP + 1) + 2);
        $display("txn latency: n=1 done after %0d cycles", lat);
        idle(2, 4'd1);
        run_txn(4'd1, 0, 1'b0, coins, gd, ge, lat);
        chk("n1_err_latency", lat, 1 + (CPC - 1) * (GAP + 1) + 1 + TO);
        $display("txn timeout: n=1 err after %0d cycles", lat);
        idle(2, 4'd0);
`endif

        // Reset during the second cola's gap.
        tick();
        buy_req      = 1'b1;
        buy_num      = 4'd3;
        exp_n        = 3;
        exp_cola     = 0;
        coin_in_cola = 0;
        ack_mode     = 1;
        txn_over     = 1'b0;
        coin_total   = 0;
        coin_q.push_back(cyc + 1);
        for (int i = 0; i < 100 && exp_cola == 0; i++) begin
            sample();
            tick();
        end
        sample();
        tick();
        chk("pre_reset_cola_cnt", 32'(cola_cnt), 1);
        chk("pre_reset_busy", 32'(busy), 1);
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst_pi_money", 32'(pi_money), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_done", 32'(done), 0);
        chk("async_rst_err", 32'(err), 0);
        chk("async_rst_cola_cnt", 32'(cola_cnt), 0);
        coin_q.delete();
        ev_q.delete();
        ack_next = 1'b0;
        po_cola  = 1'b0;
        $display("txn reset: asserted mid-run at cycle %0d, coins before reset=%0d", cyc, coin_total);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(2, '0);
        run_txn(4'd1, 1, 1'b0, coins, gd, ge, lat);
        chk("post_reset_coins", coins, 3);
        chk("post_reset_cola_cnt", 32'(cola_cnt), 1);
        chk("post_reset_done_seen", 32'(gd), 1);
        $display("txn post-reset: n=1 coins=%0d cola_cnt=%0d done=%0b", coins, cola_cnt, gd);
        idle(2, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by 100000 time units");
        $fatal(1, "watchdog");
    end
endmodule
